axi_ad7124_rtd_sample_assembler: RTL and testbench
==================================================

// Module: axi_ad7124_rtd_sample_assembler
// PURPOSE
//  Downstream of the AD7124 RTD offload sequencer. Consumes its per-byte SDI stream (4 bytes per
//  channel read: 1 command-phase byte, then 24-bit data MSB first) and assembles 24-bit codes.
//  Tags each code with its channel index, converts it to 32-bit two's complement and emits one
//  AXI-Stream beat per channel, with tlast on the final channel of a scan.
//  Never back-pressures the SPI engine; overflow drops samples and is flagged.
// PARAMETERS
//  DATA_WIDTH      8    SDI byte width; only 8 is supported (elaboration error otherwise)
//  NUM_CHANNELS    10   channels per scan; the channel tag wraps at NUM_CHANNELS-1
//  BYTES_PER_READ  4    bytes per channel read; byte 0 is discarded
//  BIPOLAR         1    1: offset-binary -> signed (invert bit 23, sign-extend); 0: zero-extend
//  FIFO_DEPTH      4    output FIFO entries; power of 2, >= 2
// PORTS
//  spi_clk          in   1   sole clock
//  spi_resetn       in   1   asynchronous active-low reset
//  enable           in   1   0: discard input, hold counters at 0
//  scan_start       in   1   1-cycle pulse: next byte is byte 0 of channel 0
//  s_sdi_valid      in   1   input byte valid
//  s_sdi_ready      out  1   constant 1
//  s_sdi_data       in   8   input byte
//  m_axis_valid     out  1   output sample valid
//  m_axis_ready     in   1   output sample accepted
//  m_axis_data      out  32  converted sample
//  m_axis_user      out  4   channel index 0..NUM_CHANNELS-1
//  m_axis_last      out  1   1 on channel NUM_CHANNELS-1
//  overflow         out  1   sticky; set on a dropped sample; cleared by scan_start
//  drop_count       out  16  dropped-sample count, saturates at 16'hFFFF; cleared by reset only
// BEHAVIOUR
//  - Reset: all counters 0, FIFO empty, m_axis_valid=0, data/user/last=0, overflow=0.
//  - byte_cnt (0..BYTES_PER_READ-1) advances on each s_sdi_valid while enable=1; byte 0 dropped,
//    bytes 1..3 shift into a 24-bit register (first byte -> bits 23:16).
//  - On the final byte: sample = BIPOLAR ? sext({~c[23],c[22:0]}) : {8'h0,c}; push
//    {last,chan,sample} to the FIFO; byte_cnt -> 0; chan_cnt wraps at NUM_CHANNELS-1.
//  - Pipeline: the registered sample is written to the FIFO 1 cycle after the final byte;
//    m_axis_valid rises the following cycle when the FIFO was empty (2-cycle min latency).
//  - FIFO full at push: sample dropped, overflow<=1, drop_count+1 (saturating); chan_cnt
//    still advances so later tags stay aligned. Simultaneous pop+push while full is accepted.
//  - scan_start: byte_cnt, chan_cnt, partial code -> 0; clears overflow; FIFO contents kept.
//    scan_start and s_sdi_valid in the same cycle: that byte counts as byte 0 of channel 0.
//  - enable=0: input bytes ignored, counters held at 0; FIFO continues to drain.
//  - Output is AXIS-compliant: data/user/last stable while valid=1 and ready=0.
//  - Reset asserted mid-scan: immediate return to reset state; the partial sample is lost.
// STRUCTURE
//  - ad7124_pkg: AD7124_CODE_W=24, CHAN_W=4, typedef struct packed {logic last; logic [3:0] chan;
//    logic [31:0] data;} ad7124_sample_t, shared with the register-map/capture blocks.
//  - Sub-module ad7124_sample_fifo: synchronous FIFO of ad7124_sample_t, FIFO_DEPTH entries,
//    full/empty flags, AXIS pop side. The assembler FSM and counters live in the top.
// TESTING
//  1 scan_start; bytes 42,80,00,00 ch0 -> data=32'h0000_0000, user=0, last=0 (BIPOLAR=1)
//  2 BIPOLAR=1: 42,00,00,01 -> 32'hFF80_0001; BIPOLAR=0: 42,FF,FF,FF -> 32'h00FF_FFFF
//  3 40 bytes, ready=1 -> 10 beats, user 0..9, last only on user=9; 11th sample user=0
//  4 ready=0, 6 samples -> 4 held in order, overflow=1, drop_count=2; ready=1 drains 4
//  5 scan_start after 2 bytes of ch3 -> next 4 bytes give user=0, no spurious beat
//  6 spi_resetn low mid-read with FIFO non-empty -> valid=0 at once, counters 0, overflow=0

Source files
------------

// File: rtl/ad7124_pkg.sv
// Shared AD7124 sample types, widths and code conversion.
// Pure definitions; no timing or flow control of its own.
package ad7124_pkg;

  localparam int AD7124_CODE_W = 24;
  localparam int CHAN_W        = 4;
  localparam int SAMPLE_W      = 32;

  typedef struct packed {
    logic              last;
    logic [CHAN_W-1:0] chan;
    logic [31:0]       data;
  } ad7124_sample_t;

  typedef enum logic {
    ST_CMD,
    ST_DATA
  } asm_state_t;

  // Bipolar codes are offset binary: flipping the MSB gives two's complement.
  function automatic logic [SAMPLE_W-1:0] code_to_sample(input logic [AD7124_CODE_W-1:0] code,
                                                          input bit bipolar);
    if (bipolar)
      return {{8{~code[23]}}, ~code[23], code[22:0]};
    return {8'h00, code};
  endfunction

endpackage

// File: rtl/axi_ad7124_rtd_sample_assembler_if.sv
// SDI byte input and AXI-Stream sample output of the RTD sample assembler.
// Plain wires; the assembler holds s_sdi_ready high and follows AXIS rules on the output.
interface axi_ad7124_rtd_sample_assembler_if #(
  parameter int DATA_WIDTH = 8
);
  import ad7124_pkg::*;

  logic                  s_sdi_valid;
  logic                  s_sdi_ready;
  logic [DATA_WIDTH-1:0] s_sdi_data;
  logic                  m_axis_valid;
  logic                  m_axis_ready;
  logic [SAMPLE_W-1:0]   m_axis_data;
  logic [CHAN_W-1:0]     m_axis_user;
  logic                  m_axis_last;

  modport slave (
    input  s_sdi_valid, s_sdi_data, m_axis_ready,
    output s_sdi_ready, m_axis_valid, m_axis_data, m_axis_user, m_axis_last
  );

  modport master (
    output s_sdi_valid, s_sdi_data, m_axis_ready,
    input  s_sdi_ready, m_axis_valid, m_axis_data, m_axis_user, m_axis_last
  );

endinterface

// File: rtl/ad7124_sample_fifo.sv
// Synchronous FIFO of tagged samples; a write shows on pop_vld the cycle after it lands.
// Writes are refused when full unless a pop happens in the same cycle.
module ad7124_sample_fifo
  import ad7124_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  ad7124_sample_t push_dat,
  output logic           full,
  output logic           pop_vld,
  input  logic           pop_rdy,
  output ad7124_sample_t pop_dat
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ad7124_sample_fifo: DEPTH must be a power of 2 and >= 2");
  end

  ad7124_sample_t mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           empty;
  logic           pop;
  logic           wr_en;

  // Extra pointer bit tells full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = pop_rdy && !empty;
  assign wr_en   = push && (!full || pop);
  assign pop_vld = !empty;
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= push_dat;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/axi_ad7124_rtd_sample_assembler.sv
// Assembles AD7124 SDI reads into channel-tagged 32-bit AXIS samples, 2 cycles final byte to valid.
// Never stalls the SDI stream; a sample arriving at a full FIFO is dropped and flagged.
module axi_ad7124_rtd_sample_assembler
  import ad7124_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_CHANNELS   = 10,
  parameter int BYTES_PER_READ = 4,
  parameter bit BIPOLAR        = 1'b1,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                                  spi_clk,
  input  logic                                  spi_resetn,
  input  logic                                  enable,
  input  logic                                  scan_start,
  axi_ad7124_rtd_sample_assembler_if.slave      bus,
  output logic                                  overflow,
  output logic [15:0]                           drop_count
);

  localparam int BC_W = $clog2(BYTES_PER_READ);

  if (DATA_WIDTH != 8) begin : g_bad_width
    $error("axi_ad7124_rtd_sample_assembler: only DATA_WIDTH=8 is supported");
  end
  if (NUM_CHANNELS < 1 || NUM_CHANNELS > 16) begin : g_bad_chan
    $error("axi_ad7124_rtd_sample_assembler: NUM_CHANNELS must be 1..16");
  end

  asm_state_t                state, state_nxt, state_cur;
  logic [BC_W-1:0]           byte_cnt, byte_nxt;
  logic [CHAN_W-1:0]         chan_cnt, chan_nxt;
  logic [AD7124_CODE_W-1:0]  code, code_nxt;
  logic                      final_byte;
  logic                      smp_vld;
  ad7124_sample_t            smp;
  ad7124_sample_t            fifo_out;
  logic                      fifo_full;
  logic                      drop;

  assign bus.s_sdi_ready = 1'b1;

  always_ff @(posedge spi_clk or negedge spi_resetn) begin
    if (!spi_resetn) begin
      state    <= ST_CMD;
      byte_cnt <= '0;
      chan_cnt <= '0;
      code     <= '0;
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_nxt;
      chan_cnt <= chan_nxt;
      code     <= code_nxt;
    end
  end

  // scan_start rewinds first, so a byte arriving with it is the command byte of channel 0.
  always_comb begin
    state_cur  = scan_start ? ST_CMD : state;
    state_nxt  = state_cur;
    byte_nxt   = scan_start ? '0 : byte_cnt;
    chan_nxt   = scan_start ? '0 : chan_cnt;
    code_nxt   = scan_start ? '0 : code;
    final_byte = 1'b0;
    if (!enable) begin
      state_nxt = ST_CMD;
      byte_nxt  = '0;
      chan_nxt  = '0;
      code_nxt  = '0;
    end else if (bus.s_sdi_valid) begin
      case (state_cur)
        ST_CMD: begin
          state_nxt = ST_DATA;
          byte_nxt  = BC_W'(1);
        end
        ST_DATA: begin
          code_nxt = {code[15:0], bus.s_sdi_data};
          if (byte_cnt == BC_W'(BYTES_PER_READ - 1)) begin
            final_byte = 1'b1;
            state_nxt  = ST_CMD;
            byte_nxt   = '0;
            chan_nxt   = (chan_cnt == CHAN_W'(NUM_CHANNELS - 1)) ? '0 : chan_cnt + CHAN_W'(1);
          end else begin
            byte_nxt = byte_cnt + BC_W'(1);
          end
        end
        default: state_nxt = ST_CMD;
      endcase
    end
  end

  always_ff @(posedge spi_clk or negedge spi_resetn) begin
    if (!spi_resetn) begin
      smp_vld <= 1'b0;
      smp     <= '0;
    end else begin
      smp_vld <= final_byte;
      if (final_byte)
        smp <= '{last: (chan_cnt == CHAN_W'(NUM_CHANNELS - 1)),
                 chan: chan_cnt,
                 data: code_to_sample(code_nxt, BIPOLAR)};
    end
  end

  assign drop = smp_vld && fifo_full && !(bus.m_axis_valid && bus.m_axis_ready);

  always_ff @(posedge spi_clk or negedge spi_resetn) begin
    if (!spi_resetn) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end else if (scan_start) begin
      overflow <= 1'b0;
    end
  end

  ad7124_sample_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (spi_clk),
    .rst_n    (spi_resetn),
    .push     (smp_vld),
    .push_dat (smp),
    .full     (fifo_full),
    .pop_vld  (bus.m_axis_valid),
    .pop_rdy  (bus.m_axis_ready),
    .pop_dat  (fifo_out)
  );

  assign bus.m_axis_data = fifo_out.data;
  assign bus.m_axis_user = fifo_out.chan;
  assign bus.m_axis_last = fifo_out.last;

endmodule

// File: tb/tb_axi_ad7124_rtd_sample_assembler.sv
// Bench for the RTD sample assembler: a bipolar and a unipolar instance share one SDI stream.
module tb_axi_ad7124_rtd_sample_assembler;
  import ad7124_pkg::*;

  typedef struct packed {
    logic [31:0] bytes;
    logic [31:0] exp_b;
    logic [31:0] exp_u;
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  user;
    logic        last;
  } exp_t;

  logic        spi_clk = 1'b0;
  logic        spi_resetn;
  logic        enable;
  logic        scan_start;
  logic        overflow, overflow_u;
  logic [15:0] drop_count, drop_count_u;
  int          checks   = 0;
  int          failures = 0;
  exp_t        q_b[$];
  exp_t        q_u[$];
  exp_t        e_b, e_u;
  logic [3:0]  m_chan;

  always #5 spi_clk = ~spi_clk;

  axi_ad7124_rtd_sample_assembler_if bus_b ();
  axi_ad7124_rtd_sample_assembler_if bus_u ();

  assign bus_u.s_sdi_valid  = bus_b.s_sdi_valid;
  assign bus_u.s_sdi_data   = bus_b.s_sdi_data;
  assign bus_u.m_axis_ready = 1'b1;

  axi_ad7124_rtd_sample_assembler #(.BIPOLAR(1'b1)) dut_b (
    .spi_clk    (spi_clk),
    .spi_resetn (spi_resetn),
    .enable     (enable),
    .scan_start (scan_start),
    .bus        (bus_b),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  axi_ad7124_rtd_sample_assembler #(.BIPOLAR(1'b0)) dut_u (
    .spi_clk    (spi_clk),
    .spi_resetn (spi_resetn),
    .enable     (enable),
    .scan_start (scan_start),
    .bus        (bus_u),
    .overflow   (overflow_u),
    .drop_count (drop_count_u)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] conv(input logic [23:0] c, input bit bip);
    logic [23:0] t;
    t = c;
    if (bip) begin
      t[23] = ~t[23];
      return {{8{t[23]}}, t};
    end
    return {8'h00, c};
  endfunction

  // Scoreboards: every handshaken beat must match the oldest expected sample.
  always @(negedge spi_clk) begin
    if (bus_b.m_axis_valid && bus_b.m_axis_ready) begin
      if (q_b.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL bip_beat: got unexpected beat data %h user %0d, expected none",
                 bus_b.m_axis_data, bus_b.m_axis_user);
      end else begin
        e_b = q_b.pop_front();
        check("bip_data", bus_b.m_axis_data, e_b.data);
        check("bip_user", 32'(bus_b.m_axis_user), 32'(e_b.user));
        check("bip_last", 32'(bus_b.m_axis_last), 32'(e_b.last));
      end
    end
  end

  always @(negedge spi_clk) begin
    if (bus_u.m_axis_valid && bus_u.m_axis_ready) begin
      if (q_u.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL uni_beat: got unexpected beat data %h user %0d, expected none",
                 bus_u.m_axis_data, bus_u.m_axis_user);
      end else begin
        e_u = q_u.pop_front();
        check("uni_data", bus_u.m_axis_data, e_u.data);
        check("uni_user", 32'(bus_u.m_axis_user), 32'(e_u.user));
        check("uni_last", 32'(bus_u.m_axis_last), 32'(e_u.last));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic ss);
    bus_b.s_sdi_valid = 1'b1;
    bus_b.s_sdi_data  = b;
    scan_start        = ss;
    @(posedge spi_clk); #1;
    bus_b.s_sdi_valid = 1'b0;
    scan_start        = 1'b0;
  endtask

  task automatic send_read(input logic [31:0] w, input logic [31:0] eb, input logic [31:0] eu,
                           input bit ss, input bit drop_b);
    if (ss) m_chan = 4'd0;
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], ss && (i == 3));
    if (!drop_b) q_b.push_back('{data: eb, user: m_chan, last: (m_chan == 4'd9)});
    q_u.push_back('{data: eu, user: m_chan, last: (m_chan == 4'd9)});
    m_chan = (m_chan == 4'd9) ? 4'd0 : m_chan + 4'd1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((q_b.size() != 0 || q_u.size() != 0) && n < 300) begin
      @(posedge spi_clk); #1;
      n++;
    end
    checks++;
    if (q_b.size() != 0 || q_u.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: got %0d/%0d beats outstanding, expected 0", name, q_b.size(), q_u.size());
    end
    repeat (4) @(posedge spi_clk);
    #1;
  endtask

  initial begin
    vec_t        vt[5];
    logic [23:0] code;

    spi_resetn         = 1'b0;
    enable             = 1'b0;
    scan_start         = 1'b0;
    bus_b.s_sdi_valid  = 1'b0;
    bus_b.s_sdi_data   = 8'h00;
    bus_b.m_axis_ready = 1'b1;
    m_chan             = 4'd0;

    vt[0] = '{32'h4280_0000, 32'h0000_0000, 32'h0080_0000};
    vt[1] = '{32'h4200_0001, 32'hFF80_0001, 32'h0000_0001};
    vt[2] = '{32'h42FF_FFFF, 32'h007F_FFFF, 32'h00FF_FFFF};
    vt[3] = '{32'h427F_FFFF, 32'hFFFF_FFFF, 32'h007F_FFFF};
    vt[4] = '{32'h4212_3456, 32'hFF92_3456, 32'h0012_3456};

    repeat (3) @(posedge spi_clk);
    #1;
    check("rst_valid", 32'(bus_b.m_axis_valid), 32'd0);
    check("rst_data", bus_b.m_axis_data, 32'd0);
    check("rst_user", 32'(bus_b.m_axis_user), 32'd0);
    check("rst_last", 32'(bus_b.m_axis_last), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    spi_resetn = 1'b1;
    enable     = 1'b1;
    @(posedge spi_clk); #1;

    // Conversion table; first byte carries scan_start.
    for (int i = 0; i < 5; i++) send_read(vt[i].bytes, vt[i].exp_b, vt[i].exp_u, i == 0, 1'b0);
    wait_drain("table");

    // Minimum latency: valid two cycles after the final byte edge.
    send_read(32'h42AB_CDEF, 32'h002B_CDEF, 32'h00AB_CDEF, 1'b1, 1'b0);
    check("lat_cycle1_valid", 32'(bus_b.m_axis_valid), 32'd0);
    @(posedge spi_clk); #1;
    check("lat_cycle2_valid", 32'(bus_b.m_axis_valid), 32'd1);
    check("lat_cycle2_data", bus_b.m_axis_data, 32'h002B_CDEF);
    wait_drain("latency");

    // Full scan plus one: tags 0..9, last on 9, then wrap to 0.
    for (int i = 0; i < 11; i++) begin
      code = {8'(i * 17), 8'(i * 3), 8'h5A};
      send_read({8'h42, code}, conv(code, 1'b1), conv(code, 1'b0), i == 0, 1'b0);
    end
    wait_drain("scan");

    // Stalled output: 4 held in order, samples 5 and 6 dropped.
    bus_b.m_axis_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      code = {8'hC0 + 8'(i), 8'h00, 8'(i)};
      send_read({8'h42, code}, conv(code, 1'b1), conv(code, 1'b0), i == 0, i >= 4);
    end
    repeat (3) @(posedge spi_clk);
    #1;
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_drop_count", 32'(drop_count), 32'd2);
    check("ovf_valid_held", 32'(bus_b.m_axis_valid), 32'd1);
    check("ovf_head_data", bus_b.m_axis_data, q_b[0].data);
    repeat (3) @(posedge spi_clk);
    #1;
    check("ovf_head_stable", bus_b.m_axis_data, q_b[0].data);
    check("ovf_head_user", 32'(bus_b.m_axis_user), 32'd0);
    bus_b.m_axis_ready = 1'b1;
    wait_drain("ovf");
    check("ovf_sticky", 32'(overflow), 32'd1);

    // scan_start mid-read of channel 3 rewinds to channel 0 and clears overflow.
    for (int i = 0; i < 3; i++) send_read(32'h4210_2030 + 32'(i), 32'hFF90_2030 + 32'(i),
                                          32'h0010_2030 + 32'(i), i == 0, 1'b0);
    check("restart_ovf_cleared", 32'(overflow), 32'd0);
    check("restart_drop_kept", 32'(drop_count), 32'd2);
    send_byte(8'h42, 1'b0);
    send_byte(8'h11, 1'b0);
    scan_start = 1'b1;
    @(posedge spi_clk); #1;
    scan_start = 1'b0;
    m_chan     = 4'd0;
    send_read(32'h4200_0102, 32'hFF80_0102, 32'h0000_0102, 1'b0, 1'b0);
    wait_drain("restart");

    // enable=0: bytes ignored, counters parked at channel 0.
    send_read(32'h4233_3333, 32'hFFB3_3333, 32'h0033_3333, 1'b0, 1'b0);
    wait_drain("pre_disable");
    enable = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(8'hE0 + 8'(i), 1'b0);
    enable = 1'b1;
    m_chan = 4'd0;
    send_read(32'h4280_0005, 32'h0000_0005, 32'h0080_0005, 1'b0, 1'b0);
    wait_drain("enable");

    // Reset mid-read with a full FIFO and overflow set.
    bus_b.m_axis_ready = 1'b0;
    for (int i = 0; i < 6; i++) send_read(32'h4270_0000 + 32'(i), 32'hFFF0_0000 + 32'(i),
                                          32'h0070_0000 + 32'(i), i == 0, i >= 4);
    send_byte(8'h42, 1'b0);
    send_byte(8'h55, 1'b0);
    check("prerst_overflow", 32'(overflow), 32'd1);
    spi_resetn = 1'b0;
    #1;
    check("midrst_valid", 32'(bus_b.m_axis_valid), 32'd0);
    check("midrst_data", bus_b.m_axis_data, 32'd0);
    check("midrst_user", 32'(bus_b.m_axis_user), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    check("midrst_drop_count", 32'(drop_count), 32'd0);
    q_b.delete();
    q_u.delete();
    m_chan = 4'd0;
    @(posedge spi_clk); #1;
    spi_resetn         = 1'b1;
    bus_b.m_axis_ready = 1'b1;
    @(posedge spi_clk); #1;
    send_read(32'h4280_00AA, 32'h0000_00AA, 32'h0080_00AA, 1'b0, 1'b0);
    wait_drain("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
